// File: rtl/mem_bist_pkg.sv
// Shared encodings for the memory BIST controller: pattern modes, FSM states
// and the checkerboard base word.
package mem_bist_pkg;

   typedef enum logic [1:0] {
      MODE_WALK1 = 2'd0,
      MODE_WALK0 = 2'd1,
      MODE_ADDR  = 2'd2,
      MODE_CHKR  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      DONE    = 3'd4
   } state_e;

   // Alternating bits with LSB=1; sliced down to the memory width (up to 64).
   localparam logic [63:0] CHKR_WORD = {32{2'b01}};

endpackage

// File: rtl/mem_bist_pattern.sv
// Expected data word for a given address and pattern mode; used both to drive
// write data and as the reference for read-back compare.
module mem_bist_pattern
   import mem_bist_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int ADDR  = 5
) (
   input  logic [ADDR-1:0]  addr,
   input  mode_e            mode,
   output logic [WIDTH-1:0] pattern
);

   logic [WIDTH-1:0] one_hot;
   logic [WIDTH-1:0] chkr;

   always_comb begin
      one_hot = WIDTH'(1) << (32'(addr) % WIDTH);
      chkr    = CHKR_WORD[WIDTH-1:0];
      pattern = '0;
      case (mode)
         MODE_WALK1: pattern = one_hot;
         MODE_WALK0: pattern = ~one_hot;
         MODE_ADDR:  pattern = WIDTH'(addr);
         MODE_CHKR:  pattern = addr[0] ? ~chkr : chkr;
         default:    pattern = '0;
      endcase
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST engine: writes a pattern to every word, reads each back with a
// fixed one-cycle latency, and reports error count and first failing word.
//
// state   | meaning
// IDLE    | waiting for start after reset
// WRITE   | write request for addr_q outstanding
// RD_REQ  | read request for addr_q outstanding
// RD_WAIT | read data for addr_q arrives; compare
// DONE    | results valid; waiting for a new start
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter  int WIDTH = 12,
   parameter  int DEPTH = 32,
   localparam int ADDR  = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ADDR:0]    err_cnt_o,
   output logic [ADDR-1:0]  fail_addr_o,
   output logic [WIDTH-1:0] fail_data_o,
   output logic             valid_o,
   output logic             wr_rd_o,
   output logic [ADDR-1:0]  addr_o,
   output logic [WIDTH-1:0] wdata_o,
   input  logic [WIDTH-1:0] rdata_i,
   input  logic             ready_i
);

   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

   state_e           state_q, state_d;
   mode_e            mode_q;
   logic [ADDR-1:0]  addr_q;
   logic [ADDR:0]    err_cnt_q;
   logic [ADDR-1:0]  fail_addr_q;
   logic [WIDTH-1:0] fail_data_q;
   logic [WIDTH-1:0] pattern;
   logic             start_ok;
   logic             last;

   assign start_ok = ((state_q == IDLE) || (state_q == DONE)) && start_i;
   assign last     = (addr_q == LAST_ADDR);

   mem_bist_pattern #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR)
   ) u_pattern (
      .addr    (addr_q),
      .mode    (mode_q),
      .pattern (pattern)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs decode only from registered state, so reset drops valid_o at once
   // and nothing combinationally follows ready_i or rdata_i.
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      valid_o = 1'b0;
      wr_rd_o = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = WRITE;
         end
         WRITE: begin
            busy_o  = 1'b1;
            valid_o = 1'b1;
            wr_rd_o = 1'b1;
            addr_o  = addr_q;
            wdata_o = pattern;
            if (ready_i && last) state_d = RD_REQ;
         end
         RD_REQ: begin
            busy_o  = 1'b1;
            valid_o = 1'b1;
            addr_o  = addr_q;
            if (ready_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            busy_o  = 1'b1;
            state_d = last ? DONE : RD_REQ;
         end
         DONE: begin
            done_o = 1'b1;
            if (start_i) state_d = WRITE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mode_q      <= MODE_WALK1;
         addr_q      <= '0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else if (start_ok) begin
         mode_q      <= mode_e'(mode_i);
         addr_q      <= '0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         case (state_q)
            WRITE: begin
               if (ready_i) addr_q <= last ? '0 : addr_q + 1'b1;
            end
            RD_WAIT: begin
               if (rdata_i != pattern) begin
                  err_cnt_q <= err_cnt_q + 1'b1;
                  if (err_cnt_q == '0) begin
                     fail_addr_q <= addr_q;
                     fail_data_q <= rdata_i;
                  end
               end
               if (!last) addr_q <= addr_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign err_cnt_o   = err_cnt_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_data_o = fail_data_q;
   assign pass_o      = done_o && (err_cnt_q == '0);

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a one-cycle-latency memory responder.
module tb_mem_bist_ctrl;

   localparam int WIDTH = 12;
   localparam int DEPTH = 32;
   localparam int ADDR  = 5;

   logic             clk_i   = 1'b0;
   logic             rst_i   = 1'b0;
   logic             start_i = 1'b0;
   logic [1:0]       mode_i  = 2'd0;
   logic             ready_i = 1'b1;
   logic [WIDTH-1:0] rdata_i;
   logic             busy_o, done_o, pass_o, valid_o, wr_rd_o;
   logic [ADDR:0]    err_cnt_o;
   logic [ADDR-1:0]  fail_addr_o, addr_o;
   logic [WIDTH-1:0] fail_data_o, wdata_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   mem_bist_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .err_cnt_o   (err_cnt_o),
      .fail_addr_o (fail_addr_o),
      .fail_data_o (fail_data_o),
      .valid_o     (valid_o),
      .wr_rd_o     (wr_rd_o),
      .addr_o      (addr_o),
      .wdata_o     (wdata_o),
      .rdata_i     (rdata_i),
      .ready_i     (ready_i)
   );

   // memory responder plus write log and stall-stability monitor
   logic [WIDTH-1:0] mem  [DEPTH];
   logic [WIDTH-1:0] wlog [DEPTH];
   logic [WIDTH-1:0] rd_q = '0;
   int               wr_cnt    = 0;
   int               stall_cnt = 0;
   int               viol      = 0;
   bit               force_b3  = 1'b0;
   bit               stall_en  = 1'b0;
   logic             snap_v    = 1'b0;
   logic [ADDR+WIDTH+1:0] snap = '0;

   assign rdata_i = force_b3 ? (rd_q & 12'hFF7) : rd_q;

   always @(posedge clk_i) begin
      if (valid_o && ready_i) begin
         if (wr_rd_o) begin
            mem[addr_o]  <= wdata_o;
            wlog[addr_o] <= wdata_o;
            wr_cnt       <= wr_cnt + 1;
         end else begin
            rd_q <= mem[addr_o];
         end
      end
      if (valid_o && !ready_i) stall_cnt <= stall_cnt + 1;
      if (snap_v && ({valid_o, wr_rd_o, addr_o, wdata_o} != snap)) viol <= viol + 1;
      snap_v <= valid_o && !ready_i;
      snap   <= {valid_o, wr_rd_o, addr_o, wdata_o};
   end

   always @(negedge clk_i) ready_i = stall_en ? ~ready_i : 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts a run, reports whether the first write appeared one cycle after
   // the start edge, and returns the clocks from that edge until done_o.
   task automatic run(input logic [1:0] m, input bit hold, output bit first_ok, output int n);
      @(negedge clk_i);
      mode_i  = m;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      if (!hold) start_i = 1'b0;
      first_ok = valid_o && wr_rd_o && (addr_o == '0) && busy_o && !done_o;
      n = 0;
      do begin
         @(posedge clk_i);
         #1;
         n++;
      end while (!done_o && n < 2000);
   endtask

   bit first_ok;
   int n, w0, s0;

   initial begin
      #12;
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_busy_done_pass", {busy_o, done_o, pass_o}, 0);
      chk("rst_err_fields", {err_cnt_o, fail_addr_o, fail_data_o}, 0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // walking ones
      w0 = wr_cnt;
      run(2'd0, 1'b0, first_ok, n);
      chk("m0_first_write", 32'(first_ok), 1);
      chk("m0_done_cycles", n, 96);
      chk("m0_pass", {pass_o, 26'(err_cnt_o)}, {1'b1, 26'd0});
      chk("m0_wr_count", wr_cnt - w0, 32);
      chk("m0_w0", wlog[0], 12'h001);
      chk("m0_w1", wlog[1], 12'h002);
      chk("m0_w11", wlog[11], 12'h800);
      chk("m0_w12", wlog[12], 12'h001);

      // walking zeros
      run(2'd1, 1'b0, first_ok, n);
      chk("m1_w5", wlog[5], 12'hFDF);
      chk("m1_w12", wlog[12], 12'hFFE);
      chk("m1_pass", 32'(pass_o), 1);

      // address-as-data with ready toggling every cycle
      stall_en = 1'b1;
      s0 = stall_cnt;
      run(2'd2, 1'b0, first_ok, n);
      stall_en = 1'b0;
      chk("m2_w31", wlog[31], 12'h01F);
      chk("m2_w7", wlog[7], 12'h007);
      chk("m2_pass", 32'(pass_o), 1);
      chk("m2_stalls_seen", 32'((stall_cnt - s0) >= 16), 1);
      chk("m2_done_cycles", n, 96 + (stall_cnt - s0));
      chk("m2_stable_in_stall", viol, 0);

      // checkerboard with read data bit 3 stuck low
      force_b3 = 1'b1;
      run(2'd3, 1'b0, first_ok, n);
      force_b3 = 1'b0;
      chk("m3_w0", wlog[0], 12'h555);
      chk("m3_w1", wlog[1], 12'hAAA);
      chk("m3_err_cnt", 32'(err_cnt_o), 16);
      chk("m3_fail_addr", 32'(fail_addr_o), 1);
      chk("m3_fail_data", 32'(fail_data_o), 12'hAA2);
      chk("m3_pass_done", {pass_o, done_o}, 2'b01);

      // reset mid-write
      @(negedge clk_i);
      mode_i  = 2'd0;
      start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      n = 0;
      while (!(valid_o && wr_rd_o && addr_o == 5'd10) && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("rst_reached_addr10", 32'(addr_o), 10);
      #2 rst_i = 1'b0;
      #1;
      chk("rst_mid_valid_busy", {valid_o, busy_o}, 0);
      chk("rst_mid_err_done", {26'(err_cnt_o), done_o}, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      run(2'd0, 1'b0, first_ok, n);
      chk("rerun_cycles", n, 96);
      chk("rerun_pass", 32'(pass_o), 1);

      // start held high through a run, then a fresh pulse after done
      run(2'd2, 1'b1, first_ok, n);
      start_i = 1'b0;
      chk("held_done_cycles", n, 96);
      @(posedge clk_i);
      #1;
      chk("held_done_stays", 32'(done_o), 1);
      run(2'd1, 1'b0, first_ok, n);
      chk("restart_clears_done", 32'(first_ok), 1);
      chk("restart_cycles", n, 96);
      chk("restart_pass", 32'(pass_o), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
